// File: rtl/rob_commit_if.sv
// rob_commit_if: groups every non-clock signal between the reorder buffer and
// the surrounding pipeline (decoder allocation/lookup, ALU/MUL result buses,
// register-bank commit port).
//   master : the pipeline side (drives allocation, results and lookup addresses)
//   slave  : the reorder buffer (drives IDs, status, lookup answers, commit port)
interface rob_commit_if #(
  parameter int REG_ADDRESS_SIZE = 5,
  parameter int REG_SIZE         = 32,
  parameter int ID_SIZE          = 3
);
  logic                        alloc_valid;
  logic [REG_ADDRESS_SIZE-1:0] alloc_dest;
  logic                        alloc_w;
  logic [ID_SIZE-1:0]          alloc_id;
  logic                        full;
  logic                        empty;

  logic                        alu_valid;
  logic [ID_SIZE-1:0]          alu_id;
  logic [REG_SIZE-1:0]         alu_value;
  logic                        mul_valid;
  logic [ID_SIZE-1:0]          mul_id;
  logic [REG_SIZE-1:0]         mul_value;

  logic [REG_ADDRESS_SIZE-1:0] dAddr1;
  logic                        dependency1;
  logic                        resolved1;
  logic [REG_SIZE-1:0]         dValue1;
  logic [REG_ADDRESS_SIZE-1:0] dAddr2;
  logic                        dependency2;
  logic                        resolved2;
  logic [REG_SIZE-1:0]         dValue2;

  logic                        commit_we;
  logic [REG_ADDRESS_SIZE-1:0] commit_addr;
  logic [REG_SIZE-1:0]         commit_value;

  modport master (
    output alloc_valid, alloc_dest, alloc_w,
    output alu_valid, alu_id, alu_value,
    output mul_valid, mul_id, mul_value,
    output dAddr1, dAddr2,
    input  alloc_id, full, empty,
    input  dependency1, resolved1, dValue1,
    input  dependency2, resolved2, dValue2,
    input  commit_we, commit_addr, commit_value
  );

  modport slave (
    input  alloc_valid, alloc_dest, alloc_w,
    input  alu_valid, alu_id, alu_value,
    input  mul_valid, mul_id, mul_value,
    input  dAddr1, dAddr2,
    output alloc_id, full, empty,
    output dependency1, resolved1, dValue1,
    output dependency2, resolved2, dValue2,
    output commit_we, commit_addr, commit_value
  );
endinterface

// File: rtl/rob_commit.sv
// rob_commit: in-order reorder buffer between the decode stage and the
// ALU/MUL units. Allocates one entry per issued instruction (handing out the
// tail ID), collects results by ID, answers the decoder's two operand
// dependency lookups and retires entries in order onto the register-bank
// write port.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset
//   rob   : rob_commit_if.slave (allocation, results, lookups, commit port)
module rob_commit #(
  parameter int REG_ADDRESS_SIZE = 5,
  parameter int REG_SIZE         = 32,
  parameter int ID_SIZE          = 3
) (
  input logic     clk,
  input logic     reset,
  rob_commit_if.slave rob
);
  localparam int ENTRIES = 2 ** ID_SIZE;

  typedef struct packed {
    logic                dep;
    logic                res;
    logic [REG_SIZE-1:0] val;
  } lookup_t;

  logic [ENTRIES-1:0]          valid_q;
  logic [ENTRIES-1:0]          done_q;
  logic [ENTRIES-1:0]          w_q;
  logic [REG_ADDRESS_SIZE-1:0] dest_q  [ENTRIES];
  logic [REG_SIZE-1:0]         value_q [ENTRIES];

  logic [ID_SIZE-1:0] head;
  logic [ID_SIZE-1:0] tail;
  logic [ID_SIZE:0]   count;

  logic full;
  logic alloc_fire;
  logic commit_fire;
  logic alu_hit;
  logic mul_hit;

  lookup_t look1;
  lookup_t look2;

  assign full         = (count == (ID_SIZE+1)'(ENTRIES));
  assign rob.full     = full;
  assign rob.empty    = (count == '0);
  assign rob.alloc_id = tail;

  // A full buffer refuses allocation even if the head retires this cycle.
  assign alloc_fire  = rob.alloc_valid && !full;

  // done_q is registered, so a result can only retire the cycle after it lands.
  assign commit_fire = valid_q[head] && done_q[head];

  // Results for empty or already-completed slots are dropped; ALU beats MUL
  // when both name the same ID.
  assign alu_hit = rob.alu_valid && valid_q[rob.alu_id] && !done_q[rob.alu_id];
  assign mul_hit = rob.mul_valid && valid_q[rob.mul_id] && !done_q[rob.mul_id] &&
                   !(rob.alu_valid && (rob.alu_id == rob.mul_id));

  assign rob.commit_we    = commit_fire && w_q[head] && (dest_q[head] != '0);
  assign rob.commit_addr  = dest_q[head];
  assign rob.commit_value = value_q[head];

  // Scanning from tail (oldest slot position) up to tail-1 and keeping the
  // last hit yields the youngest writer. Registered state only, so a slot
  // allocated this cycle is invisible and a retiring one is still seen.
  function automatic lookup_t do_lookup(input logic [REG_ADDRESS_SIZE-1:0] addr);
    lookup_t            r;
    logic               found;
    logic [ID_SIZE-1:0] idx;
    logic [ID_SIZE-1:0] cand;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < ENTRIES; k++) begin
      idx = tail + ID_SIZE'(k);
      if (valid_q[idx] && w_q[idx] && (dest_q[idx] == addr) && (addr != '0)) begin
        found = 1'b1;
        cand  = idx;
      end
    end
    r.dep = found;
    r.res = 1'b0;
    r.val = '0;
    if (found) begin
      if (done_q[cand]) begin
        r.res = 1'b1;
        r.val = value_q[cand];
      end else if (rob.alu_valid && (rob.alu_id == cand)) begin
        r.res = 1'b1;
        r.val = rob.alu_value;
      end else if (rob.mul_valid && (rob.mul_id == cand)) begin
        r.res = 1'b1;
        r.val = rob.mul_value;
      end else begin
        r.val = value_q[cand];
      end
    end
    return r;
  endfunction

  always_comb begin
    look1 = do_lookup(rob.dAddr1);
    look2 = do_lookup(rob.dAddr2);
  end

  assign rob.dependency1 = look1.dep;
  assign rob.resolved1   = look1.res;
  assign rob.dValue1     = look1.val;
  assign rob.dependency2 = look2.dep;
  assign rob.resolved2   = look2.res;
  assign rob.dValue2     = look2.val;

  // Index collisions cannot occur below: a completing slot is not done (so it
  // is not the retiring head) and the allocated tail slot is never valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      if (alu_hit) begin
        done_q[rob.alu_id]  <= 1'b1;
        value_q[rob.alu_id] <= rob.alu_value;
      end
      if (mul_hit) begin
        done_q[rob.mul_id]  <= 1'b1;
        value_q[rob.mul_id] <= rob.mul_value;
      end
      if (commit_fire) begin
        valid_q[head] <= 1'b0;
        head          <= head + ID_SIZE'(1);
      end
      if (alloc_fire) begin
        valid_q[tail] <= 1'b1;
        done_q[tail]  <= 1'b0;
        w_q[tail]     <= rob.alloc_w;
        dest_q[tail]  <= rob.alloc_dest;
        tail          <= tail + ID_SIZE'(1);
      end
      case ({alloc_fire, commit_fire})
        2'b10:   count <= count + (ID_SIZE+1)'(1);
        2'b01:   count <= count - (ID_SIZE+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: self-checking bench for rob_commit. A queue-based model of
// the in-flight instructions predicts every output each cycle; a table of
// directed vectors with hand-derived expectations and a few hand-written
// sequences cover the corner cases, followed by a randomized run.
module tb_rob_commit;
  logic clk;
  logic reset;

  rob_commit_if bus ();

  rob_commit dut (
    .clk   (clk),
    .reset (reset),
    .rob   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          av;
    logic [4:0]  ad;
    bit          aw;
    bit          alv;
    logic [2:0]  alid;
    logic [31:0] alval;
    bit          mlv;
    logic [2:0]  mlid;
    logic [31:0] mlval;
    logic [4:0]  a1;
    logic [4:0]  a2;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [2:0]  e_aid;
    bit          e_empty;
    bit          e_full;
    bit          e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wval;
    bit          e_dep1;
    bit          e_res1;
    logic [31:0] e_val1;
    bit          e_dep2;
  } vec_t;

  typedef struct {
    logic [2:0]  id;
    bit          w;
    logic [4:0]  dest;
    bit          done;
    logic [31:0] value;
  } ent_t;

  ent_t  q[$];
  int    next_id;
  bit    model_valid;
  int    total_checks;
  int    pass_count;
  vec_t  vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic stim_t S(bit av, logic [4:0] ad, bit aw,
                              bit alv, logic [2:0] alid, logic [31:0] alval,
                              bit mlv, logic [2:0] mlid, logic [31:0] mlval,
                              logic [4:0] a1, logic [4:0] a2);
    stim_t s;
    s.rst = 1'b0; s.av = av; s.ad = ad; s.aw = aw;
    s.alv = alv; s.alid = alid; s.alval = alval;
    s.mlv = mlv; s.mlid = mlid; s.mlval = mlval;
    s.a1 = a1; s.a2 = a2;
    return s;
  endfunction

  function automatic stim_t idle(logic [4:0] a1, logic [4:0] a2);
    return S(0, 0, 0, 0, 0, 0, 0, 0, 0, a1, a2);
  endfunction

  task automatic addVec(input stim_t s, input logic [2:0] aid, input bit emp, input bit ful,
                        input bit we, input logic [4:0] waddr, input logic [31:0] wval,
                        input bit dep1, input bit res1, input logic [31:0] val1, input bit dep2);
    vec_t v;
    v.s = s; v.e_aid = aid; v.e_empty = emp; v.e_full = ful; v.e_we = we;
    v.e_waddr = waddr; v.e_wval = wval; v.e_dep1 = dep1; v.e_res1 = res1;
    v.e_val1 = val1; v.e_dep2 = dep2;
    vecs.push_back(v);
  endtask

  // Youngest in-flight writer of the address, with same-cycle forwarding.
  function automatic void ref_lookup(input stim_t s, input logic [4:0] a,
                                     output bit dep, output bit res, output logic [31:0] val);
    dep = 0; res = 0; val = '0;
    if (a != 0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].w && q[i].dest == a) begin
          dep = 1;
          if (q[i].done) begin res = 1; val = q[i].value; end
          else if (s.alv && s.alid == q[i].id) begin res = 1; val = s.alval; end
          else if (s.mlv && s.mlid == q[i].id) begin res = 1; val = s.mlval; end
          break;
        end
      end
    end
  endfunction

  task automatic model_compare(input stim_t s);
    bit          dep, res, cwe;
    logic [31:0] val;
    checkOutput("full", {31'd0, bus.full}, {31'd0, q.size() == 8});
    checkOutput("empty", {31'd0, bus.empty}, {31'd0, q.size() == 0});
    checkOutput("alloc_id", {29'd0, bus.alloc_id}, 32'(next_id));
    cwe = (q.size() > 0) && q[0].done && q[0].w && (q[0].dest != 0);
    checkOutput("commit_we", {31'd0, bus.commit_we}, {31'd0, cwe});
    if (cwe) begin
      checkOutput("commit_addr", {27'd0, bus.commit_addr}, {27'd0, q[0].dest});
      checkOutput("commit_value", bus.commit_value, q[0].value);
    end
    ref_lookup(s, s.a1, dep, res, val);
    checkOutput("dependency1", {31'd0, bus.dependency1}, {31'd0, dep});
    checkOutput("resolved1", {31'd0, bus.resolved1}, {31'd0, res});
    if (res || !dep) checkOutput("dValue1", bus.dValue1, val);
    ref_lookup(s, s.a2, dep, res, val);
    checkOutput("dependency2", {31'd0, bus.dependency2}, {31'd0, dep});
    checkOutput("resolved2", {31'd0, bus.resolved2}, {31'd0, res});
    if (res || !dep) checkOutput("dValue2", bus.dValue2, val);
  endtask

  task automatic model_update(input stim_t s);
    bit commit, was_full;
    if (s.rst) begin
      q.delete();
      next_id = 0;
      return;
    end
    commit   = (q.size() > 0) && q[0].done;
    was_full = (q.size() == 8);
    foreach (q[i]) begin
      if (s.alv && q[i].id == s.alid && !q[i].done) begin
        q[i].done = 1; q[i].value = s.alval;
      end else if (s.mlv && q[i].id == s.mlid && !q[i].done && !(s.alv && s.alid == s.mlid)) begin
        q[i].done = 1; q[i].value = s.mlval;
      end
    end
    if (commit) void'(q.pop_front());
    if (s.av && !was_full) begin
      ent_t e;
      e.id = 3'(next_id); e.w = s.aw; e.dest = s.ad; e.done = 0; e.value = '0;
      q.push_back(e);
      next_id = (next_id + 1) % 8;
    end
  endtask

  // Drive one cycle's inputs after the falling edge and compare against the model.
  task automatic applyStimulus(input stim_t s);
    @(negedge clk);
    reset           = s.rst;
    bus.alloc_valid = s.av;
    bus.alloc_dest  = s.ad;
    bus.alloc_w     = s.aw;
    bus.alu_valid   = s.alv;
    bus.alu_id      = s.alid;
    bus.alu_value   = s.alval;
    bus.mul_valid   = s.mlv;
    bus.mul_id      = s.mlid;
    bus.mul_value   = s.mlval;
    bus.dAddr1      = s.a1;
    bus.dAddr2      = s.a2;
    #1;
    if (model_valid) model_compare(s);
  endtask

  task automatic advance(input stim_t s);
    @(posedge clk);
    model_update(s);
  endtask

  task automatic cycle(input stim_t s);
    applyStimulus(s);
    advance(s);
  endtask

  initial begin
    stim_t s;
    total_checks = 0;
    pass_count   = 0;
    next_id      = 0;
    model_valid  = 0;
    reset = 1'b1;
    bus.alloc_valid = 0; bus.alloc_dest = 0; bus.alloc_w = 0;
    bus.alu_valid = 0; bus.alu_id = 0; bus.alu_value = 0;
    bus.mul_valid = 0; bus.mul_id = 0; bus.mul_value = 0;
    bus.dAddr1 = 0; bus.dAddr2 = 0;

    // Directed cycle table, starting from an empty buffer with head = tail = 0.
    //         av ad  aw alv id val      mlv id val     a1  a2       aid e f we wa wval       d1 r1 v1       d2
    addVec(S(1, 5,  1, 0, 0, 0,        0, 0, 0,       5,  0), 0, 1, 0, 0, 0, 0,         0, 0, 0,         0);
    addVec(S(0, 0,  0, 1, 0, 'h1234,   0, 0, 0,       5,  0), 1, 0, 0, 0, 0, 0,         1, 1, 'h1234,    0);
    addVec(idle(5, 0),                                        1, 0, 0, 1, 5, 'h1234,    1, 1, 'h1234,    0);
    addVec(idle(5, 0),                                        1, 1, 0, 0, 0, 0,         0, 0, 0,         0);
    addVec(S(1, 3,  1, 0, 0, 0,        0, 0, 0,       3,  4), 1, 1, 0, 0, 0, 0,         0, 0, 0,         0);
    addVec(S(1, 4,  1, 0, 0, 0,        0, 0, 0,       3,  4), 2, 0, 0, 0, 0, 0,         1, 0, 0,         0);
    addVec(S(0, 0,  0, 0, 0, 0,        1, 2, 'h44,    3,  4), 3, 0, 0, 0, 0, 0,         1, 0, 0,         1);
    addVec(idle(3, 4),                                        3, 0, 0, 0, 0, 0,         1, 0, 0,         1);
    addVec(S(0, 0,  0, 1, 1, 'h33,     0, 0, 0,       3,  4), 3, 0, 0, 0, 0, 0,         1, 1, 'h33,      1);
    addVec(idle(3, 4),                                        3, 0, 0, 1, 3, 'h33,      1, 1, 'h33,      1);
    addVec(idle(3, 4),                                        3, 0, 0, 1, 4, 'h44,      0, 0, 0,         1);
    addVec(S(1, 7,  1, 0, 0, 0,        0, 0, 0,       7,  0), 3, 1, 0, 0, 0, 0,         0, 0, 0,         0);
    addVec(S(1, 7,  1, 1, 3, 'h11,     0, 0, 0,       7,  0), 4, 0, 0, 0, 0, 0,         1, 1, 'h11,      0);
    addVec(idle(7, 0),                                        5, 0, 0, 1, 7, 'h11,      1, 0, 0,         0);
    addVec(S(0, 0,  0, 1, 4, 'h22,     0, 0, 0,       7,  0), 5, 0, 0, 0, 0, 0,         1, 1, 'h22,      0);
    addVec(idle(7, 0),                                        5, 0, 0, 1, 7, 'h22,      1, 1, 'h22,      0);
    addVec(S(1, 9,  0, 0, 0, 0,        0, 0, 0,       9,  0), 5, 1, 0, 0, 0, 0,         0, 0, 0,         0);
    addVec(S(1, 0,  1, 0, 0, 0,        0, 0, 0,       9,  0), 6, 0, 0, 0, 0, 0,         0, 0, 0,         0);
    addVec(S(0, 0,  0, 1, 5, 'h55,     1, 6, 'h66,    0,  0), 7, 0, 0, 0, 0, 0,         0, 0, 0,         0);
    addVec(idle(0, 0),                                        7, 0, 0, 0, 0, 0,         0, 0, 0,         0);
    addVec(idle(0, 0),                                        7, 0, 0, 0, 0, 0,         0, 0, 0,         0);
    addVec(idle(0, 0),                                        7, 1, 0, 0, 0, 0,         0, 0, 0,         0);
    addVec(S(1, 10, 1, 0, 0, 0,        0, 0, 0,       10, 0), 7, 1, 0, 0, 0, 0,         0, 0, 0,         0);
    addVec(S(0, 0,  0, 1, 7, 'hAA,     1, 7, 'hBB,    10, 0), 0, 0, 0, 0, 0, 0,         1, 1, 'hAA,      0);
    addVec(idle(10, 0),                                       0, 0, 0, 1, 10, 'hAA,     1, 1, 'hAA,      0);
    addVec(S(0, 0,  0, 1, 7, 'hCC,     0, 0, 0,       10, 0), 0, 1, 0, 0, 0, 0,         0, 0, 0,         0);
    addVec(idle(10, 0),                                       0, 1, 0, 0, 0, 0,         0, 0, 0,         0);

    // Reset state.
    s = idle(0, 0);
    s.rst = 1;
    cycle(s);
    model_valid = 1;
    applyStimulus(idle(1, 0));
    checkOutput("reset_empty", {31'd0, bus.empty}, 32'd1);
    checkOutput("reset_full", {31'd0, bus.full}, 32'd0);
    checkOutput("reset_alloc_id", {29'd0, bus.alloc_id}, 32'd0);
    checkOutput("reset_commit_we", {31'd0, bus.commit_we}, 32'd0);
    checkOutput("reset_dependency1", {31'd0, bus.dependency1}, 32'd0);
    advance(idle(1, 0));

    // Fill all eight slots, then try a ninth allocation.
    for (int i = 0; i < 8; i++) begin
      s = S(1, 5'(i + 1), 1, 0, 0, 0, 0, 0, 0, 8, 1);
      applyStimulus(s);
      checkOutput("fill_alloc_id", {29'd0, bus.alloc_id}, 32'(i));
      advance(s);
    end
    s = S(1, 9, 1, 0, 0, 0, 0, 0, 0, 8, 1);
    applyStimulus(s);
    checkOutput("fill_full", {31'd0, bus.full}, 32'd1);
    checkOutput("fill_wrap_alloc_id", {29'd0, bus.alloc_id}, 32'd0);
    advance(s);
    applyStimulus(idle(8, 9));
    checkOutput("ninth_ignored_full", {31'd0, bus.full}, 32'd1);
    checkOutput("ninth_not_visible", {31'd0, bus.dependency2}, 32'd0);
    checkOutput("fill_dep_r8", {31'd0, bus.dependency1}, 32'd1);
    advance(idle(8, 9));

    // Full with head completing, then allocation attempted during its commit.
    s = S(0, 0, 0, 1, 0, 'h77, 0, 0, 0, 1, 0);
    cycle(s);
    s = S(1, 12, 1, 0, 0, 0, 0, 0, 0, 12, 1);
    applyStimulus(s);
    checkOutput("full_commit_we", {31'd0, bus.commit_we}, 32'd1);
    checkOutput("full_commit_addr", {27'd0, bus.commit_addr}, 32'd1);
    checkOutput("full_commit_value", bus.commit_value, 32'h77);
    advance(s);
    applyStimulus(idle(12, 0));
    checkOutput("after_commit_full", {31'd0, bus.full}, 32'd0);
    checkOutput("after_commit_alloc_id", {29'd0, bus.alloc_id}, 32'd0);
    checkOutput("blocked_alloc_invisible", {31'd0, bus.dependency1}, 32'd0);
    advance(idle(12, 0));

    // Reset with entries still pending, alongside a same-cycle allocate/complete.
    s = S(1, 3, 1, 1, 1, 'h99, 0, 0, 0, 2, 0);
    s.rst = 1;
    cycle(s);
    applyStimulus(idle(2, 3));
    checkOutput("midreset_empty", {31'd0, bus.empty}, 32'd1);
    checkOutput("midreset_commit_we", {31'd0, bus.commit_we}, 32'd0);
    checkOutput("midreset_alloc_id", {29'd0, bus.alloc_id}, 32'd0);
    checkOutput("midreset_dependency1", {31'd0, bus.dependency1}, 32'd0);
    advance(idle(2, 3));

    // Directed table.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].s);
      checkOutput("vec_alloc_id", {29'd0, bus.alloc_id}, {29'd0, vecs[i].e_aid});
      checkOutput("vec_empty", {31'd0, bus.empty}, {31'd0, vecs[i].e_empty});
      checkOutput("vec_full", {31'd0, bus.full}, {31'd0, vecs[i].e_full});
      checkOutput("vec_commit_we", {31'd0, bus.commit_we}, {31'd0, vecs[i].e_we});
      if (vecs[i].e_we) begin
        checkOutput("vec_commit_addr", {27'd0, bus.commit_addr}, {27'd0, vecs[i].e_waddr});
        checkOutput("vec_commit_value", bus.commit_value, vecs[i].e_wval);
      end
      checkOutput("vec_dependency1", {31'd0, bus.dependency1}, {31'd0, vecs[i].e_dep1});
      checkOutput("vec_resolved1", {31'd0, bus.resolved1}, {31'd0, vecs[i].e_res1});
      if (vecs[i].e_res1 || !vecs[i].e_dep1)
        checkOutput("vec_dValue1", bus.dValue1, vecs[i].e_val1);
      checkOutput("vec_dependency2", {31'd0, bus.dependency2}, {31'd0, vecs[i].e_dep2});
      advance(vecs[i].s);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      s.rst   = ($urandom_range(0, 299) == 0);
      s.av    = ($urandom_range(0, 99) < 55);
      s.ad    = 5'($urandom_range(0, 7));
      s.aw    = ($urandom_range(0, 3) != 0);
      s.alv   = ($urandom_range(0, 99) < 45);
      s.alid  = 3'($urandom_range(0, 7));
      if (q.size() > 0 && $urandom_range(0, 3) != 0) s.alid = q[$urandom_range(0, q.size() - 1)].id;
      s.alval = $urandom;
      s.mlv   = ($urandom_range(0, 99) < 40);
      s.mlid  = 3'($urandom_range(0, 7));
      if (q.size() > 0 && $urandom_range(0, 3) != 0) s.mlid = q[$urandom_range(0, q.size() - 1)].id;
      s.mlval = $urandom;
      s.a1    = 5'($urandom_range(0, 7));
      s.a2    = 5'($urandom_range(0, 7));
      cycle(s);
    end

    $display("%0d/%0d checks passed", pass_count, total_checks);
    $finish;
  end
endmodule
